csr_regfile: RTL and testbench
==============================

CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 Parameter WIDTH, default 32: data width; only 32 is supported.
REQ-002 Parameter MISA_VALUE, default 32'h4000_0100: constant returned on a read of misa (RV32I).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n_i  input  1  asynchronous reset, active low.
REQ-006 csr_re_i  input  1  CSR read access is in progress.
REQ-007 csr_raddr_i  input  12  CSR read address.
REQ-008 csr_rdata_o  output  32  combinational read data; this value drives operand_b of the CSR ALU.
REQ-009 csr_we_i  input  1  CSR write request.
REQ-010 csr_waddr_i  input  12  CSR write address.
REQ-011 csr_wdata_i  input  32  write data, taken from the CSR ALU result.
REQ-012 instr_retired_i  input  1  one instruction retired this cycle.
REQ-013 csr_illegal_o  output  1  combinational flag marking an illegal access.

Function
REQ-014 The block SHALL implement the following CSRs:
- mstatus 0x300
- misa 0x301 (read-only)
- mtvec 0x305
- mscratch 0x340
- mepc 0x341
- mcause 0x342
- mcycle/mcycleh 0xB00/0xB80
- minstret/minstreth 0xB02/0xB82
- read-only aliases cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82
REQ-015 csr_rdata_o SHALL show the current register value at csr_raddr_i with zero latency, and SHALL be 0 for unimplemented addresses.
REQ-016 mstatus: only MIE (bit 3) and MPIE (bit 7) are writable; all other bits read 0.
REQ-017 mtvec[1:0] and mepc[1:0] SHALL be forced to 0 on write (direct mode, word aligned); mscratch and mcause are fully writable.
REQ-018 A write SHALL take effect at the next rising edge when csr_we_i=1 and csr_illegal_o=0; the written value is visible on csr_rdata_o in the following cycle.
REQ-019 csr_illegal_o=1 when either of these holds:
- csr_re_i=1 and csr_raddr_i is unimplemented;
- csr_we_i=1 and csr_waddr_i is unimplemented, or csr_waddr_i[11:10]==2'b11, or the address is misa.
REQ-020 When csr_illegal_o=1, no state SHALL change due to the write.
REQ-021 mcycle: 64-bit counter, +1 every cycle out of reset.
REQ-022 minstret: 64-bit counter, +1 in each cycle where instr_retired_i=1.
REQ-023 Both counters SHALL wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-024 Write to either half of a counter in the same cycle as its increment: the write wins, the other half holds, and no increment occurs that cycle.
REQ-025 A write to mcycle SHALL NOT affect minstret, and vice versa.
REQ-026 A read and a write to the same address in the same cycle SHALL return the old value (no bypass).

Reset
REQ-027 On rst_n_i=0, immediately and independent of clk_i, the following SHALL clear to 0:
- mstatus, mtvec, mscratch, mepc, mcause;
- both counters.
REQ-028 Reset asserted mid-count SHALL discard any in-flight write and increment; after deassertion, mcycle reads 1 after the first rising edge.
REQ-029 Outputs are combinational from state and inputs; during reset, csr_rdata_o reflects the cleared state.

Configuration
REQ-030 Macro CSR_COUNTERS_EN gates the counters.
- Defined: the mcycle/minstret counters and their aliases exist as specified.
- Undefined: no counter flops exist; the counter addresses are treated as unimplemented (read 0, csr_illegal_o=1 on access), and instr_retired_i is ignored.

Verification
REQ-031 Reset, then write mscratch=32'hDEAD_BEEF -> next cycle csr_rdata_o=32'hDEAD_BEEF at 0x340, csr_illegal_o=0.
REQ-032 Write mepc=32'h0000_1237, and write mstatus=32'hFFFF_FFFF -> mepc reads 32'h0000_1234; mstatus reads 32'h0000_0088.
REQ-033 Write 0xC00 or 0x301, and read 0x7FF -> csr_illegal_o=1 each time, with no state change; the 0x7FF read returns 0.
REQ-034 Write mcycle=32'hFFFF_FFFF and mcycleh=32'hFFFF_FFFF, then one idle cycle -> mcycle and mcycleh read 0 (wrap).
REQ-035 Hold instr_retired_i=1 for 5 cycles, with a minstret write of 32'h10 in cycle 3 -> after cycle 5, minstret=32'h12.
REQ-036 Assert rst_n_i mid-count with a pending write -> counters and registers read 0 immediately; CSR_COUNTERS_EN undefined -> reads of 0xB00 give 0 with csr_illegal_o=1.

Source files
------------

// File: rtl/csr_regfile.sv
// Machine-mode CSR file (mstatus/misa/mtvec/mscratch/mepc/mcause + optional 64-bit counters under CSR_COUNTERS_EN).
// Reads and the illegal flag are combinational (zero latency); writes commit on the next rising edge; no backpressure.
module csr_regfile #(
  parameter int                 WIDTH      = 32,
  parameter logic [WIDTH-1:0]   MISA_VALUE = 32'h4000_0100
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             csr_re_i,
  input  logic [11:0]      csr_raddr_i,
  output logic [WIDTH-1:0] csr_rdata_o,
  input  logic             csr_we_i,
  input  logic [11:0]      csr_waddr_i,
  input  logic [WIDTH-1:0] csr_wdata_i,
  input  logic             instr_retired_i,
  output logic             csr_illegal_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [2*WIDTH-1:0] CNT_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
`endif

  function automatic logic is_impl(input logic [11:0] addr);
    logic hit;
    hit = 1'b0;
    case (addr)
      ADDR_MSTATUS, ADDR_MISA, ADDR_MTVEC,
      ADDR_MSCRATCH, ADDR_MEPC, ADDR_MCAUSE: hit = 1'b1;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH,
      ADDR_CYCLE, ADDR_CYCLEH, ADDR_INSTRET, ADDR_INSTRETH: hit = 1'b1;
`endif
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  logic             mie_q;
  logic             mpie_q;
  logic [WIDTH-1:2] mtvec_q;
  logic [WIDTH-1:0] mscratch_q;
  logic [WIDTH-1:2] mepc_q;
  logic [WIDTH-1:0] mcause_q;

  logic rd_bad;
  logic wr_bad;
  logic wr_en;

  // Any illegal condition in the cycle, including a bad read, suppresses the write.
  assign rd_bad        = csr_re_i && !is_impl(csr_raddr_i);
  assign wr_bad        = csr_we_i && (!is_impl(csr_waddr_i) ||
                                      (csr_waddr_i[11:10] == 2'b11) ||
                                      (csr_waddr_i == ADDR_MISA));
  assign csr_illegal_o = rd_bad || wr_bad;
  assign wr_en         = csr_we_i && !csr_illegal_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (wr_en) begin
      case (csr_waddr_i)
        ADDR_MSTATUS: begin
          mie_q  <= csr_wdata_i[3];
          mpie_q <= csr_wdata_i[7];
        end
        ADDR_MTVEC:    mtvec_q    <= csr_wdata_i[WIDTH-1:2];
        ADDR_MSCRATCH: mscratch_q <= csr_wdata_i;
        ADDR_MEPC:     mepc_q     <= csr_wdata_i[WIDTH-1:2];
        ADDR_MCAUSE:   mcause_q   <= csr_wdata_i;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [2*WIDTH-1:0] mcycle_q;
  logic [2*WIDTH-1:0] minstret_q;

  // A write to either half replaces that cycle's increment; the other half holds.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcycle_q <= '0;
    end else if (wr_en && (csr_waddr_i == ADDR_MCYCLE)) begin
      mcycle_q[WIDTH-1:0] <= csr_wdata_i;
    end else if (wr_en && (csr_waddr_i == ADDR_MCYCLEH)) begin
      mcycle_q[2*WIDTH-1:WIDTH] <= csr_wdata_i;
    end else begin
      mcycle_q <= mcycle_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      minstret_q <= '0;
    end else if (wr_en && (csr_waddr_i == ADDR_MINSTRET)) begin
      minstret_q[WIDTH-1:0] <= csr_wdata_i;
    end else if (wr_en && (csr_waddr_i == ADDR_MINSTRETH)) begin
      minstret_q[2*WIDTH-1:WIDTH] <= csr_wdata_i;
    end else if (instr_retired_i) begin
      minstret_q <= minstret_q + CNT_ONE;
    end
  end
`else
  logic unused_retired;
  assign unused_retired = instr_retired_i;
`endif

  always_comb begin
    csr_rdata_o = '0;
    case (csr_raddr_i)
      ADDR_MSTATUS: begin
        csr_rdata_o[3] = mie_q;
        csr_rdata_o[7] = mpie_q;
      end
      ADDR_MISA:     csr_rdata_o = MISA_VALUE;
      ADDR_MTVEC:    csr_rdata_o = {mtvec_q, 2'b00};
      ADDR_MSCRATCH: csr_rdata_o = mscratch_q;
      ADDR_MEPC:     csr_rdata_o = {mepc_q, 2'b00};
      ADDR_MCAUSE:   csr_rdata_o = mcause_q;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE,   ADDR_CYCLE:    csr_rdata_o = mcycle_q[WIDTH-1:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:   csr_rdata_o = mcycle_q[2*WIDTH-1:WIDTH];
      ADDR_MINSTRET, ADDR_INSTRET:  csr_rdata_o = minstret_q[WIDTH-1:0];
      ADDR_MINSTRETH,ADDR_INSTRETH: csr_rdata_o = minstret_q[2*WIDTH-1:WIDTH];
`endif
      default: csr_rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: directed literal checks plus randomized traffic scored every cycle against a behavioural CSR model.
`timescale 1ns/1ps
module tb_csr_regfile;

`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  localparam logic [31:0] MISA = 32'h4000_0100;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        re      = 1'b0;
  logic [11:0] raddr   = 12'h0;
  logic        we      = 1'b0;
  logic [11:0] waddr   = 12'h0;
  logic [31:0] wdata   = 32'h0;
  logic        ret     = 1'b0;
  logic [31:0] rdata;
  logic        illegal;

  int vectors = 0;
  int errs    = 0;

  csr_regfile dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .csr_re_i(re), .csr_raddr_i(raddr), .csr_rdata_o(rdata),
    .csr_we_i(we), .csr_waddr_i(waddr), .csr_wdata_i(wdata),
    .instr_retired_i(ret), .csr_illegal_o(illegal)
  );

  always #5 clk = ~clk;

  // Behavioural model state: architectural register values and full 64-bit counters.
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342: return 1'b1;
      12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: return CNT;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (!m_impl(a)) return 32'h0;
    case (a)
      12'h300: return m_mstatus;
      12'h301: return MISA;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_illegal();
    bit r_bad, w_bad;
    r_bad = re && !m_impl(raddr);
    w_bad = we && (!m_impl(waddr) || waddr >= 12'hC00 || waddr == 12'h301);
    return r_bad || w_bad;
  endfunction

  task automatic m_clear();
    m_mstatus = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_cyc = 0; m_ins = 0;
  endtask

  initial m_clear();

  // Compare on the falling edge, then advance the model to what the next rising edge must produce.
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    bit          exp_il, wr, cyc_w, ins_w;
    if (!rst_n) m_clear();
    exp_rd = m_read(raddr);
    exp_il = m_illegal();
    vectors++;
    if (rdata !== exp_rd || illegal !== exp_il) begin
      errs++;
      $display("FAIL model_cmp t=%0t raddr=%h waddr=%h: got rdata=%h ill=%b, want rdata=%h ill=%b",
               $time, raddr, waddr, rdata, illegal, exp_rd, exp_il);
    end
    if (rst_n) begin
      wr    = we && !exp_il;
      cyc_w = wr && (waddr == 12'hB00 || waddr == 12'hB80);
      ins_w = wr && (waddr == 12'hB02 || waddr == 12'hB82);
      if (wr) begin
        case (waddr)
          12'h300: m_mstatus  = wdata & 32'h88;
          12'h305: m_mtvec    = wdata & ~32'h3;
          12'h340: m_mscratch = wdata;
          12'h341: m_mepc     = wdata & ~32'h3;
          12'h342: m_mcause   = wdata;
          12'hB00: m_cyc[31:0]  = wdata;
          12'hB80: m_cyc[63:32] = wdata;
          12'hB02: m_ins[31:0]  = wdata;
          12'hB82: m_ins[63:32] = wdata;
          default: ;
        endcase
      end
      if (!cyc_w) m_cyc = m_cyc + 64'd1;
      if (!ins_w && ret) m_ins = m_ins + 64'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] exp_rd, input logic exp_il);
    vectors++;
    if (rdata !== exp_rd || illegal !== exp_il) begin
      errs++;
      $display("FAIL %s: got rdata=%h ill=%b, want rdata=%h ill=%b", nm, rdata, illegal, exp_rd, exp_il);
    end
  endtask

  task automatic drive(input logic r, input logic [11:0] ra, input logic w,
                       input logic [11:0] wa, input logic [31:0] wd, input logic rt);
    @(posedge clk);
    #1;
    re = r; raddr = ra; we = w; waddr = wa; wdata = wd; ret = rt;
    #1;
  endtask

  logic [11:0] addr_pool [16] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                  12'hC02, 12'hC82, 12'h7FF, 12'h344};

  function automatic logic [11:0] pick_addr();
    int k;
    k = $urandom_range(0, 16);
    if (k == 16) return 12'($urandom);
    return addr_pool[k];
  endfunction

  initial begin
    #3;
    raddr = 12'h340;
    chk("reset_mscratch", 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; re = 1'b1; raddr = 12'hB00;
    drive(1, 12'hB00, 0, 12'h0, 32'h0, 0);
    chk("mcycle_first_edge", CNT ? 32'h1 : 32'h0, !CNT);

    drive(1, 12'h340, 1, 12'h340, 32'hDEAD_BEEF, 0);
    chk("rd_wr_same_no_bypass", 32'h0, 1'b0);
    drive(1, 12'h340, 0, 12'h0, 32'h0, 0);
    chk("mscratch_written", 32'hDEAD_BEEF, 1'b0);

    drive(0, 12'h0, 1, 12'h341, 32'h0000_1237, 0);
    drive(0, 12'h0, 1, 12'h300, 32'hFFFF_FFFF, 0);
    drive(1, 12'h341, 0, 12'h0, 32'h0, 0);
    chk("mepc_aligned", 32'h0000_1234, 1'b0);
    drive(1, 12'h300, 0, 12'h0, 32'h0, 0);
    chk("mstatus_mask", 32'h0000_0088, 1'b0);
    drive(0, 12'h0, 1, 12'h305, 32'hFFFF_FFFF, 0);
    drive(1, 12'h305, 0, 12'h0, 32'h0, 0);
    chk("mtvec_aligned", 32'hFFFF_FFFC, 1'b0);

    drive(0, 12'h340, 1, 12'hC00, 32'h55, 0);
    chk("wr_c00_illegal", 32'hDEAD_BEEF, 1'b1);
    drive(0, 12'h340, 1, 12'h301, 32'h0, 0);
    chk("wr_misa_illegal", 32'hDEAD_BEEF, 1'b1);
    drive(1, 12'h7FF, 0, 12'h0, 32'h0, 0);
    chk("rd_7ff_illegal", 32'h0, 1'b1);
    drive(1, 12'h7FF, 1, 12'h340, 32'h0, 0);
    chk("bad_rd_blocks_wr", 32'h0, 1'b1);
    drive(1, 12'h340, 0, 12'h0, 32'h0, 0);
    chk("mscratch_unchanged", 32'hDEAD_BEEF, 1'b0);
    drive(1, 12'h301, 0, 12'h0, 32'h0, 0);
    chk("misa_value", MISA, 1'b0);

    drive(0, 12'h0, 1, 12'hB00, 32'hFFFF_FFFF, 0);
    drive(0, 12'h0, 1, 12'hB80, 32'hFFFF_FFFF, 0);
    drive(0, 12'h0, 0, 12'h0, 32'h0, 0);
    drive(1, 12'hB00, 0, 12'h0, 32'h0, 0);
    chk("mcycle_wrap_lo", 32'h0, !CNT);
    drive(1, 12'hB80, 0, 12'h0, 32'h0, 0);
    chk("mcycle_wrap_hi", 32'h0, !CNT);

    drive(0, 12'h0, 0, 12'h0, 32'h0, 1);
    drive(0, 12'h0, 0, 12'h0, 32'h0, 1);
    drive(0, 12'h0, 1, 12'hB02, 32'h10, 1);
    drive(0, 12'h0, 0, 12'h0, 32'h0, 1);
    drive(0, 12'h0, 0, 12'h0, 32'h0, 1);
    drive(1, 12'hB02, 0, 12'h0, 32'h0, 0);
    chk("minstret_write_wins", CNT ? 32'h12 : 32'h0, !CNT);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 299) != 0);
      re    = $urandom_range(0, 1);
      raddr = pick_addr();
      we    = ($urandom_range(0, 2) != 0);
      waddr = pick_addr();
      wdata = $urandom;
      ret   = $urandom_range(0, 1);
    end

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 12'h340, 1, 12'h340, 32'h1234_5678, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_immediate_mscratch", 32'h0, 1'b0);
    raddr = 12'hB00;
    #1;
    chk("rst_immediate_mcycle", 32'h0, !CNT);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    re = 1'b0;
    drive(1, 12'hB00, 0, 12'h0, 32'h0, 0);
    chk("mcycle_after_rst", CNT ? 32'h1 : 32'h0, !CNT);
    repeat (3) drive(1, 12'h340, 0, 12'h0, 32'h0, 0);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
